data_memory_ctrl: RTL

Parametrised, pipelined data-memory controller for the RISC-V CPU. It owns a byte-addressed storage array and accepts one load or store per cycle over a valid/ready request channel. It performs little-endian lane steering for byte, half and word accesses, sign- or zero-extends loads, and flags misaligned accesses. Every request returns exactly one in-order response after a configurable latency, and the response channel supports backpressure. The block sits between the execute/memory stage and the data store.

---
 rtl/data_memory_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/data_memory_ctrl.sv
// Data-memory controller: byte-addressed store with lane steering,
// load extension, misalignment flagging and a stallable response pipe.
module data_memory_ctrl #(
  parameter int DEPTH_BYTES = 2048,
  parameter int ADDR_W      = 32,
  parameter int RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_us,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [15:0]       err_cnt
);

  localparam int IW = $clog2(DEPTH_BYTES);

  logic [7:0]               r_mem [DEPTH_BYTES];
  logic [RD_LAT-1:0]        r_v;
  logic [RD_LAT-1:0]        r_e;
  logic [RD_LAT-1:0][31:0]  r_d;
  logic [15:0]              r_cnt;

  logic          w_stall;
  logic          w_acc;
  logic          w_err;
  logic [IW-1:0] w_i0;
  logic [IW-1:0] w_i1;
  logic [IW-1:0] w_i2;
  logic [IW-1:0] w_i3;
  logic [7:0]    w_b0;
  logic [7:0]    w_b1;
  logic [7:0]    w_b2;
  logic [7:0]    w_b3;
  logic [31:0]   w_ld;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_stall   = rsp_valid && !rsp_ready;
  assign req_ready = rst_n && !w_stall;
  assign w_acc     = req_valid && req_ready;

  // Upper address bits only alias the array; the index wraps.
  assign w_unused = ^req_addr[ADDR_W-1:IW];
  assign w_i0 = req_addr[IW-1:0];
  assign w_i1 = w_i0 + IW'(1);
  assign w_i2 = w_i0 + IW'(2);
  assign w_i3 = w_i0 + IW'(3);

  assign w_b0 = r_mem[w_i0];
  assign w_b1 = r_mem[w_i1];
  assign w_b2 = r_mem[w_i2];
  assign w_b3 = r_mem[w_i3];

  always_comb begin
    w_err = 1'b0;
    w_ld  = '0;
    unique case (req_size)
      2'b00: begin
        w_ld = {{24{!req_us && w_b0[7]}}, w_b0};
      end
      2'b01: begin
        w_err = req_addr[0];
        w_ld  = {{16{!req_us && w_b1[7]}}, w_b1, w_b0};
      end
      2'b10: begin
        w_err = |req_addr[1:0];
        w_ld  = {w_b3, w_b2, w_b1, w_b0};
      end
      default: begin
        w_err = 1'b1;
      end
    endcase
  end

  assign w_rdata = (req_we || w_err) ? 32'd0 : w_ld;

  // Storage is never reset; accepted stores survive a reset.
  always_ff @(posedge clk) begin
    if (w_acc && req_we && !w_err) begin
      r_mem[w_i0] <= req_wdata[7:0];
      if (req_size != 2'b00) begin
        r_mem[w_i1] <= req_wdata[15:8];
      end
      if (req_size == 2'b10) begin
        r_mem[w_i2] <= req_wdata[23:16];
        r_mem[w_i3] <= req_wdata[31:24];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      r_e <= '0;
      r_d <= '0;
    end else if (!w_stall) begin
      r_v[0] <= w_acc;
      r_e[0] <= w_acc && w_err;
      r_d[0] <= w_acc ? w_rdata : 32'd0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_v[i] <= r_v[i-1];
        r_e[i] <= r_e[i-1];
        r_d[i] <= r_d[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (rsp_valid && rsp_ready && rsp_err
                 && r_cnt != 16'hFFFF) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign rsp_valid = r_v[RD_LAT-1];
  assign rsp_err   = r_e[RD_LAT-1];
  assign rsp_rdata = r_d[RD_LAT-1];
  assign err_cnt   = r_cnt;

endmodule
